// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris score keeper.
//   - FSM state encoding for the score/level controller
//   - points awarded per number of cleared lines
//   - renderer colour constants (normal and level-up highlight)
//   - BCD_MAX, the saturating score value
package tetris_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_LINES = 2'd2
  } state_e;

  localparam logic [3:0] PTS_1 = 4'd1;
  localparam logic [3:0] PTS_2 = 4'd3;
  localparam logic [3:0] PTS_3 = 4'd5;
  localparam logic [3:0] PTS_4 = 4'd8;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } colour_t;

  localparam colour_t COLOR_NORMAL = '{r: 3'b111, g: 3'b111, b: 2'b11};
  localparam colour_t COLOR_FLASH  = '{r: 3'b111, g: 3'b000, b: 2'b00};

  // Points for a line count; illegal counts award nothing.
  function automatic logic [3:0] points_for(input logic [2:0] lines);
    case (lines)
      3'd1:    points_for = PTS_1;
      3'd2:    points_for = PTS_2;
      3'd3:    points_for = PTS_3;
      3'd4:    points_for = PTS_4;
      default: points_for = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_inc4.sv
// Combinational +1 on a 4-digit packed-BCD value.
//   value_i : current score, [15:12] most significant digit
//   value_o : value_i + 1 in BCD, or value_i unchanged when it is 9999
// Each digit wraps 9 -> 0 and ripples a carry into the next digit, so the
// result is always legal BCD.
module bcd_inc4
  import tetris_pkg::*;
(
  input  logic [15:0] value_i,
  output logic [15:0] value_o
);

  logic       carry;
  logic [3:0] digit;

  always_comb begin
    value_o = value_i;
    carry   = 1'b1;
    digit   = 4'd0;
    if (value_i != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        digit = value_i[4*i +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            value_o[4*i +: 4] = 4'd0;
          end else begin
            value_o[4*i +: 4] = digit + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tetris_score_bcd.sv
// Score/level keeper feeding the VGA digit renderer.
//   clk        : system clock
//   rst        : asynchronous reset, active low
//   game_clr   : synchronous new-game clear, overrides all other inputs
//   clr_valid  : line-clear event valid
//   clr_lines  : lines cleared by the event (1..4 legal, others dropped)
//   clr_ready  : high while the block can accept an event
//   value      : 4-digit packed-BCD score
//   level      : current level (binary, saturates at MAX_LEVEL)
//   saturated  : score has reached 9999
//   R/G/B_control : registered renderer colour, highlighted after a level-up
module tetris_score_bcd
  import tetris_pkg::*;
#(
  parameter int LINES_PER_LEVEL = 10,
  parameter int FLASH_CYCLES    = 50000000,
  parameter int MAX_LEVEL       = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_clr,
  input  logic        clr_valid,
  input  logic [2:0]  clr_lines,
  output logic        clr_ready,
  output logic [15:0] value,
  output logic [3:0]  level,
  output logic        saturated,
  output logic [2:0]  R_control,
  output logic [2:0]  G_control,
  output logic [1:0]  B_control
);

  localparam int FLASH_W = (FLASH_CYCLES < 1) ? 1 : $clog2(FLASH_CYCLES + 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);
  localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);
  localparam logic [4:0]         LPL        = 5'(LINES_PER_LEVEL);
  localparam logic [3:0]         MAX_LVL    = 4'(MAX_LEVEL);

  state_e               state_q,     state_d;
  logic [15:0]          value_q,     value_d;
  logic [3:0]           level_q,     level_d;
  logic [3:0]           line_acc_q,  line_acc_d;
  logic [2:0]           lines_q,     lines_d;
  logic [3:0]           pts_q,       pts_d;
  logic                 sat_q,       sat_d;
  logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
  colour_t              colour_q,    colour_d;

  logic [15:0] value_inc;
  logic [4:0]  line_sum;

  bcd_inc4 u_bcd_inc4 (
    .value_i (value_q),
    .value_o (value_inc)
  );

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    level_d     = level_q;
    line_acc_d  = line_acc_q;
    lines_d     = lines_q;
    pts_d       = pts_q;
    sat_d       = sat_q;
    flash_cnt_d = flash_cnt_q;
    line_sum    = {1'b0, line_acc_q} + {2'b00, lines_q};

    // The highlight timer free-runs down; a level-up below reloads it.
    if (flash_cnt_q != '0) begin
      flash_cnt_d = flash_cnt_q - FLASH_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        // Illegal line counts are consumed but change nothing.
        if (clr_valid && (clr_lines inside {[3'd1:3'd4]})) begin
          pts_d   = points_for(clr_lines);
          lines_d = clr_lines;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        // One BCD +1 per cycle keeps every intermediate score legal for the
        // renderer, which samples without regard to this clock.
        value_d = value_inc;
        pts_d   = pts_q - 4'd1;
        if (pts_q == 4'd1) begin
          state_d = ST_LINES;
        end
      end
      ST_LINES: begin
        if (line_sum >= LPL) begin
          line_acc_d  = 4'(line_sum - LPL);
          level_d     = (level_q >= MAX_LVL) ? MAX_LVL : level_q + 4'd1;
          flash_cnt_d = FLASH_LOAD;
        end else begin
          line_acc_d = line_sum[3:0];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (value_d == BCD_MAX) begin
      sat_d = 1'b1;
    end

    if (game_clr) begin
      state_d     = ST_IDLE;
      value_d     = '0;
      level_d     = '0;
      line_acc_d  = '0;
      lines_d     = '0;
      pts_d       = '0;
      sat_d       = 1'b0;
      flash_cnt_d = '0;
    end

    // Colour is registered from the next timer value so the highlight lasts
    // exactly FLASH_CYCLES cycles and drops on the same edge as a clear.
    colour_d = (flash_cnt_d != '0) ? COLOR_FLASH : COLOR_NORMAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      level_q     <= '0;
      line_acc_q  <= '0;
      lines_q     <= '0;
      pts_q       <= '0;
      sat_q       <= 1'b0;
      flash_cnt_q <= '0;
      colour_q    <= COLOR_NORMAL;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      level_q     <= level_d;
      line_acc_q  <= line_acc_d;
      lines_q     <= lines_d;
      pts_q       <= pts_d;
      sat_q       <= sat_d;
      flash_cnt_q <= flash_cnt_d;
      colour_q    <= colour_d;
    end
  end

  assign clr_ready = (state_q == ST_IDLE);
  assign value     = value_q;
  assign level     = level_q;
  assign saturated = sat_q;
  assign R_control = colour_q.r;
  assign G_control = colour_q.g;
  assign B_control = colour_q.b;

endmodule
